// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit for the MEM stage of the pipeline.
// It takes one load or store request from the EX/MEM register and runs it as
// a single transfer on a req/ack data-memory bus. Only one transfer is in
// flight at a time. The unit formats load data and holds the upstream
// pipeline until the response is ready. It reports misaligned accesses,
// illegal width codes and bus timeouts.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/we/mask/addr/wdata
//                            request from EX/MEM; mask is the width code
//                            BYTE=0 HALF=1 WORD=2 UBYTE=3 UHALF=4
//   stall                    hold the upstream pipeline registers
//   mem_req/we/addr/be/wdata bus request with a word-aligned address, byte
//                            enables and store data replicated on each lane
//   mem_ack, mem_rdata       bus completion and read word
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata                formatted load data; 0 for stores and faults
//   rsp_err                  00 ok, 01 misaligned/illegal, 10 bus timeout
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_mask,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] M_BYTE  = 3'd0;
    localparam logic [2:0] M_HALF  = 3'd1;
    localparam logic [2:0] M_WORD  = 3'd2;
    localparam logic [2:0] M_UBYTE = 3'd3;
    localparam logic [2:0] M_UHALF = 3'd4;

    // Last busy-cycle index before giving up. It is only used when TIMEOUT != 0.
    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        we_q;
    logic [2:0]  mask_q;
    logic [1:0]  lane_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] cnt_q;
    logic [31:0] rdata_q;
    logic [1:0]  err_q;

    logic        req_bad;
    logic [3:0]  req_be;
    logic [31:0] req_wrep;
    logic        tmo_hit;
    logic [31:0] load_fmt;

    // Request classification: alignment / legality, byte enables, lane data
    always_comb begin
        req_bad  = 1'b0;
        req_be   = 4'b1111;
        req_wrep = req_wdata;
        case (req_mask)
            M_BYTE, M_UBYTE: begin
                req_be   = 4'b0001 << req_addr[1:0];
                req_wrep = {4{req_wdata[7:0]}};
            end
            M_HALF, M_UHALF: begin
                req_bad  = req_addr[0];
                req_be   = 4'b0011 << {req_addr[1], 1'b0};
                req_wrep = {2{req_wdata[15:0]}};
            end
            M_WORD: req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Load formatting: pick the addressed lane, then extend by width code
    always_comb begin
        logic [31:0] shifted;
        shifted = mem_rdata >> {lane_q, 3'b000};
        case (mask_q)
            M_BYTE:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            M_UBYTE: load_fmt = {24'd0, shifted[7:0]};
            M_HALF:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            M_UHALF: load_fmt = {16'd0, shifted[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = req_bad ? S_RESP : S_BUSY;
            S_BUSY: if (mem_ack || tmo_hit) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req   = (state_q == S_BUSY);
        rsp_valid = (state_q == S_RESP);
        // While reset is asserted, the pipeline must not be held, even with a
        // request pending.
        stall     = ((state_q == S_IDLE) && req_valid && !rst) || (state_q == S_BUSY);
    end

    // Bus-side registers and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            mask_q  <= 3'd0;
            lane_q  <= 2'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_bad) begin
                        rdata_q <= 32'd0;
                        err_q   <= 2'b01;
                    end else if (req_valid) begin
                        we_q    <= req_we;
                        mask_q  <= req_mask;
                        lane_q  <= req_addr[1:0];
                        addr_q  <= {req_addr[31:2], 2'b00};
                        be_q    <= req_be;
                        wdata_q <= req_wrep;
                        cnt_q   <= 32'd0;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 32'd1;
                    // An ack in the timeout cycle still counts as a success.
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'd0 : load_fmt;
                        err_q   <= 2'b00;
                    end else if (tmo_hit) begin
                        rdata_q <= 32'd0;
                        err_q   <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
